// File: rtl/mem_frame_reader.sv
// Generic show-ahead FIFO; the head entry is visible on rd_dat whenever rd_vld is high.
// Latency: a write shows up on rd_vld/rd_dat one cycle later.
// Backpressure: pops on rd_vld & rd_rdy; a write while full is dropped, so the producer must credit-limit.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && (count != CW'(DEPTH));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Streams frames out of a region-partitioned packet SRAM from (start,end,extra) descriptors.
// Latency: pRD_LAT+1 cycles from read issue to o_valid; one word per cycle within a frame.
// Backpressure: reads are issued only against free output-buffer credit, so i_ready=0 stalls issue, never drops data.
module mem_frame_reader #(
    parameter int pDEPTH_RAM  = 4608,
    parameter int pDATA_WIDTH = 8,
    parameter int pREG1_HI    = 1534,
    parameter int pREG2_LO    = 1535,
    parameter int pREG2_HI    = 3070,
    parameter int pREG3_LO    = 3071,
    parameter int pRD_LAT     = 2,
    parameter int pOUT_DEPTH  = 4,
    localparam int AW = $clog2(pDEPTH_RAM),
    localparam int DW = 4 * pDATA_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [2*AW+1:0] i_desc,
    input  logic            i_desc_valid,
    output logic            o_desc_rd,
    output logic            o_en_read,
    output logic [AW-1:0]   o_adr_out,
    input  logic [DW-1:0]   i_data,
    output logic [DW-1:0]   o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_sof,
    output logic            o_eof,
    output logic [1:0]      o_extra_byte,
    output logic [2:0]      o_free,
    output logic            o_err,
    output logic            o_busy
);
    localparam logic [AW-1:0] LAST  = AW'(pDEPTH_RAM - 1);
    localparam logic [AW-1:0] R1_HI = AW'(pREG1_HI);
    localparam logic [AW-1:0] R2_LO = AW'(pREG2_LO);
    localparam logic [AW-1:0] R2_HI = AW'(pREG2_HI);
    localparam logic [AW-1:0] R3_LO = AW'(pREG3_LO);
    localparam int CW  = $clog2(pOUT_DEPTH + 1);
    localparam int CRW = $clog2(pOUT_DEPTH + pRD_LAT + 1);

    typedef enum logic {IDLE, READ} state_t;

    typedef struct packed {
        logic [1:0] rgn;
        logic [1:0] extra;
        logic       eof;
        logic       sof;
    } tag_t;

    typedef struct packed {
        tag_t          tag;
        logic [DW-1:0] dat;
    } entry_t;

    function automatic logic [1:0] region_of(input logic [AW-1:0] a);
        if (a <= R1_HI)      return 2'd1;
        else if (a <= R2_HI) return 2'd2;
        else                 return 2'd3;
    endfunction

    function automatic logic [AW-1:0] rgn_lo(input logic [1:0] r);
        case (r)
            2'd1:    return '0;
            2'd2:    return R2_LO;
            default: return R3_LO;
        endcase
    endfunction

    function automatic logic [AW-1:0] rgn_hi(input logic [1:0] r);
        case (r)
            2'd1:    return R1_HI;
            2'd2:    return R2_HI;
            default: return LAST;
        endcase
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      cur;
    logic [AW-1:0]      end_q;
    logic [1:0]         extra_q;
    logic [1:0]         rgn_q;
    logic               first_q;
    logic               issue;
    logic               desc_take;
    logic [AW-1:0]      d_start;
    logic [AW-1:0]      d_end;
    logic [1:0]         d_extra;
    logic [1:0]         d_rgn;
    logic               d_bad;
    logic [pRD_LAT-1:0] pipe_vld;
    tag_t               pipe_tag [pRD_LAT];
    tag_t               issue_tag;
    logic [CRW-1:0]     inflight;
    logic [CW-1:0]      buf_count;
    logic               credit_ok;
    entry_t             wr_ent;
    entry_t             head;
    logic               head_vld;
    logic               pop_eof;

    assign d_start = i_desc[AW-1:0];
    assign d_end   = i_desc[2*AW-1:AW];
    assign d_extra = i_desc[2*AW+:2];
    assign d_rgn   = region_of(d_start);
    // The end address must sit in the same region as the start, or the frame would wrap wrongly.
    assign d_bad   = (d_start > LAST) || (d_end > LAST) ||
                     (d_end < rgn_lo(d_rgn)) || (d_end > rgn_hi(d_rgn));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < pRD_LAT; i++) inflight = inflight + CRW'(pipe_vld[i]);
    end

    assign credit_ok = (CRW'(buf_count) + inflight) < CRW'(pOUT_DEPTH);
    assign issue_tag = '{rgn: rgn_q, extra: extra_q, eof: (cur == end_q), sof: first_q};

    always_comb begin
        state_nxt = state;
        o_desc_rd = 1'b0;
        o_err     = 1'b0;
        issue     = 1'b0;
        desc_take = 1'b0;
        case (state)
            IDLE: begin
                if (i_desc_valid && !i_reset) begin
                    o_desc_rd = 1'b1;
                    if (d_bad) begin
                        o_err = 1'b1;
                    end else begin
                        desc_take = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (cur == end_q) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_en_read = issue;
    assign o_adr_out = cur;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            cur     <= '0;
            end_q   <= '0;
            extra_q <= '0;
            rgn_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (desc_take) begin
                cur     <= d_start;
                end_q   <= d_end;
                extra_q <= d_extra;
                rgn_q   <= d_rgn;
                first_q <= 1'b1;
            end else if (issue) begin
                cur     <= (cur == rgn_hi(rgn_q)) ? rgn_lo(rgn_q) : cur + AW'(1);
                first_q <= 1'b0;
            end
        end
    end

    // Frame tags ride alongside the SRAM read so they meet i_data in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < pRD_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_tag[0] <= issue_tag;
            for (int i = 1; i < pRD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign wr_ent = '{tag: pipe_tag[pRD_LAT-1], dat: i_data};

    fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (pOUT_DEPTH)
    ) u_out_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .wr_vld  (pipe_vld[pRD_LAT-1]),
        .wr_dat  (wr_ent),
        .rd_vld  (head_vld),
        .rd_rdy  (i_ready),
        .rd_dat  (head),
        .count   (buf_count)
    );

    assign o_valid      = head_vld;
    assign o_data       = head.dat;
    assign o_sof        = head_vld && head.tag.sof;
    assign o_eof        = head_vld && head.tag.eof;
    assign o_extra_byte = (head_vld && head.tag.eof) ? head.tag.extra : 2'd0;
    assign o_busy       = (state != IDLE) || (pipe_vld != '0) || head_vld;
    assign pop_eof      = head_vld && i_ready && head.tag.eof;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_free <= '0;
        end else begin
            o_free[0] <= pop_eof && (head.tag.rgn == 2'd1);
            o_free[1] <= pop_eof && (head.tag.rgn == 2'd2);
            o_free[2] <= pop_eof && (head.tag.rgn == 2'd3);
        end
    end
endmodule

// File: tb/tb_mem_frame_reader.sv
// Randomized bench for mem_frame_reader: SRAM model with fixed read latency, descriptor queue, frame-level reference model.
module tb_mem_frame_reader;
    localparam int D    = 4608;
    localparam int AW   = 13;
    localparam int L    = 2;
    localparam int OD   = 4;
    localparam int R1HI = 1534;
    localparam int R2LO = 1535;
    localparam int R2HI = 3070;
    localparam int R3LO = 3071;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
        logic [1:0]  x;
    } word_t;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [2*AW+1:0] i_desc = '0;
    logic            i_desc_valid = 1'b0;
    logic            o_desc_rd;
    logic            o_en_read;
    logic [AW-1:0]   o_adr_out;
    logic [31:0]     i_data;
    logic [31:0]     o_data;
    logic            o_valid;
    logic            i_ready;
    logic            o_sof;
    logic            o_eof;
    logic [1:0]      o_extra_byte;
    logic [2:0]      o_free;
    logic            o_err;
    logic            o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 i_clk = ~i_clk;

    mem_frame_reader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_desc(i_desc), .i_desc_valid(i_desc_valid),
        .o_desc_rd(o_desc_rd), .o_en_read(o_en_read), .o_adr_out(o_adr_out), .i_data(i_data),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sof(o_sof), .o_eof(o_eof),
        .o_extra_byte(o_extra_byte), .o_free(o_free), .o_err(o_err), .o_busy(o_busy)
    );

    // SRAM model: request captured mid-cycle, data presented L cycles after the enable cycle.
    logic [31:0]   sram [D];
    logic [31:0]   rd_pipe [L];
    logic          req_en = 1'b0;
    logic [AW-1:0] req_adr = '0;
    always @(negedge i_clk) begin
        req_en  <= o_en_read;
        req_adr <= o_adr_out;
    end
    always @(posedge i_clk) begin
        rd_pipe[0] <= req_en ? sram[req_adr] : 32'hDEAD_BEEF;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_data = rd_pipe[L-1];

    // Descriptor FIFO model (show-ahead) and output monitor.
    logic [2*AW+1:0] desc_q [$];
    logic            pop_now = 1'b0;
    logic [AW-1:0]   addr_q [$];
    int              acyc_q [$];
    word_t           out_q [$];
    int              ecyc_q [$];
    logic [2:0]      free_q [$];
    int              fcyc_q [$];
    int              n_err = 0;
    int              n_drd = 0;
    int              exp_addr [$];
    word_t           exp_w [$];
    logic [2:0]      exp_free [$];

    always @(posedge i_clk) cyc = cyc + 1;

    always @(negedge i_clk) begin
        pop_now = o_desc_rd;
        if (!i_reset) begin
            if (o_en_read) begin addr_q.push_back(o_adr_out); acyc_q.push_back(cyc); end
            if (o_valid && i_ready) begin
                out_q.push_back('{d: o_data, sof: o_sof, eof: o_eof, x: o_extra_byte});
                if (o_eof) ecyc_q.push_back(cyc);
            end
            if (o_free != 3'b000) begin free_q.push_back(o_free); fcyc_q.push_back(cyc); end
            if (o_err) n_err = n_err + 1;
            if (o_desc_rd) n_drd = n_drd + 1;
        end
    end

    always @(posedge i_clk) begin
        #1;
        if (pop_now && desc_q.size() > 0) void'(desc_q.pop_front());
        i_desc_valid = (desc_q.size() > 0);
        i_desc       = (desc_q.size() > 0) ? desc_q[0] : '0;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    function automatic logic [2*AW+1:0] mk(input int s, input int e, input int x);
        return {2'(x), 13'(e), 13'(s)};
    endfunction

    function automatic int reg_lo(input int s);
        if (s <= R1HI) return 0;
        if (s <= R2HI) return R2LO;
        return R3LO;
    endfunction

    function automatic int reg_hi(input int s);
        if (s <= R1HI) return R1HI;
        if (s <= R2HI) return R2HI;
        return D - 1;
    endfunction

    // Reference: a frame is len = (end-start mod size)+1 consecutive addresses modulo its region.
    task automatic model_frame(input int s, input int e, input int x);
        int lo, sz, len, a;
        word_t w;
        lo  = reg_lo(s);
        sz  = reg_hi(s) - lo + 1;
        len = (((e - s) % sz) + sz) % sz + 1;
        for (int i = 0; i < len; i++) begin
            a = lo + ((s - lo + i) % sz);
            exp_addr.push_back(a);
            w.d   = sram[a];
            w.sof = (i == 0);
            w.eof = (i == len - 1);
            w.x   = w.eof ? 2'(x) : 2'd0;
            exp_w.push_back(w);
        end
        exp_free.push_back((s <= R1HI) ? 3'b001 : (s <= R2HI) ? 3'b010 : 3'b100);
    endtask

    task automatic clear_q();
        addr_q.delete(); acyc_q.delete(); out_q.delete(); ecyc_q.delete();
        free_q.delete(); fcyc_q.delete(); exp_addr.delete(); exp_w.delete(); exp_free.delete();
        n_err = 0; n_drd = 0;
    endtask

    task automatic wait_done(output bit ok);
        int k = 0;
        while ((o_busy || i_desc_valid || desc_q.size() != 0) && k < 3000) begin tick(); k++; end
        tick(3);
        ok = (k < 3000);
    endtask

    task automatic test_reset();
        logic [56:0] v;
        i_reset = 1'b1; i_ready = 1'b0;
        tick(2);
        v = {o_desc_rd, o_en_read, o_valid, o_sof, o_eof, o_free, o_err, o_busy, o_adr_out, o_data, o_extra_byte};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
        i_reset = 1'b0;
        tick(2);
        checks++;
        if ({o_valid, o_busy, o_en_read, o_desc_rd} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset got %b want 0000", {o_valid, o_busy, o_en_read, o_desc_rd});
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_q(); i_ready = 1'b1;
        model_frame(10, 12, 3);
        desc_q.push_back(mk(10, 12, 3));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (addr_q.size() != 3 || out_q.size() != 3) begin
            errors++; $display("FAIL basic_count reads=%0d words=%0d want 3 3", addr_q.size(), out_q.size());
        end
        foreach (exp_addr[i]) if (i < addr_q.size()) begin
            checks++;
            if (int'(addr_q[i]) != exp_addr[i] || acyc_q[i] != acyc_q[0] + i) begin
                errors++; $display("FAIL basic_read%0d addr=%0d cyc=+%0d want %0d +%0d", i, addr_q[i], acyc_q[i] - acyc_q[0], exp_addr[i], i);
            end
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, out_q[i], exp_w[i]); end
        end
        checks++;
        if (free_q.size() != 1 || ecyc_q.size() != 1 || free_q[0] !== 3'b001 || fcyc_q[0] != ecyc_q[0] + 1) begin
            errors++; $display("FAIL basic_free n=%0d val=%b want 1 001 one cycle after eof", free_q.size(), (free_q.size() > 0) ? free_q[0] : 3'b0);
        end
    endtask

    task automatic test_wrap_single();
        bit ok;
        clear_q(); i_ready = 1'b1;
        model_frame(3069, 1536, 1); desc_q.push_back(mk(3069, 1536, 1));
        model_frame(3071, 3071, 2); desc_q.push_back(mk(3071, 3071, 2));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (addr_q.size() != 5 || out_q.size() != 5 || free_q.size() != 2) begin
            errors++; $display("FAIL wrap_count reads=%0d words=%0d frees=%0d want 5 5 2", addr_q.size(), out_q.size(), free_q.size());
        end
        foreach (exp_addr[i]) if (i < addr_q.size()) begin
            checks++;
            if (int'(addr_q[i]) != exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d got %0d want %0d", i, addr_q[i], exp_addr[i]); end
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_word%0d got %h want %h", i, out_q[i], exp_w[i]); end
        end
        foreach (exp_free[i]) if (i < free_q.size()) begin
            checks++;
            if (free_q[i] !== exp_free[i]) begin errors++; $display("FAIL wrap_free%0d got %b want %b", i, free_q[i], exp_free[i]); end
        end
    endtask

    task automatic test_bad_desc();
        bit ok;
        clear_q(); i_ready = 1'b1;
        desc_q.push_back(mk(10, 2000, 0));
        model_frame(37, 40, 1); desc_q.push_back(mk(37, 40, 1));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bad_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (n_err != 1 || n_drd != 2) begin errors++; $display("FAIL bad_pulses err=%0d pops=%0d want 1 2", n_err, n_drd); end
        checks++;
        if (addr_q.size() != 4 || out_q.size() != 4) begin
            errors++; $display("FAIL bad_count reads=%0d words=%0d want 4 4", addr_q.size(), out_q.size());
        end
        foreach (exp_w[i]) if (i < out_q.size() && i < addr_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i] || int'(addr_q[i]) != exp_addr[i]) begin
                errors++; $display("FAIL bad_next%0d got %0d/%h want %0d/%h", i, addr_q[i], out_q[i], exp_addr[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int s, e, k;
        logic [34:0] held, now;
        clear_q(); i_ready = 1'b1;
        s = $urandom_range(0, R1HI);
        e = (s + 19 > R1HI) ? s + 19 - (R1HI + 1) : s + 19;
        model_frame(s, e, 2); desc_q.push_back(mk(s, e, 2));
        k = 0;
        while (out_q.size() < 3 && k < 100) begin tick(); k++; end
        i_ready = 1'b0;
        @(negedge i_clk);
        held = {o_valid, o_sof, o_eof, o_data};
        checks++;
        if (held[34] !== 1'b1) begin errors++; $display("FAIL bp_valid_at_stall got %b want 1", held[34]); end
        repeat (9) begin
            @(negedge i_clk);
            now = {o_valid, o_sof, o_eof, o_data};
            checks++;
            if (now !== held) begin errors++; $display("FAIL bp_stable got %h want %h", now, held); end
        end
        tick();
        checks++;
        if (addr_q.size() - out_q.size() > OD) begin
            errors++; $display("FAIL bp_buffered got %0d want <= %0d", addr_q.size() - out_q.size(), OD);
        end
        i_ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (out_q.size() != 20) begin errors++; $display("FAIL bp_count got %0d want 20", out_q.size()); end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, out_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int kind, s, e, x, lo, sz, len, nbad, k;
        clear_q(); nbad = 0;
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 5);
            x = $urandom_range(0, 3);
            if (kind == 0) begin
                s = $urandom_range(0, R1HI); e = $urandom_range(R3LO, D - 1); nbad++;
            end else if (kind == 1) begin
                s = $urandom_range(D, 8191); e = $urandom_range(0, 100); nbad++;
            end else begin
                case ($urandom_range(1, 3))
                    1: s = $urandom_range(0, R1HI);
                    2: s = $urandom_range(R2LO, R2HI);
                    default: s = $urandom_range(R3LO, D - 1);
                endcase
                lo = reg_lo(s); sz = reg_hi(s) - lo + 1;
                len = $urandom_range(1, 12);
                e = lo + ((s - lo + len - 1) % sz);
                model_frame(s, e, x);
            end
            desc_q.push_back(mk(s, e, x));
        end
        k = 0;
        while ((o_busy || i_desc_valid || desc_q.size() != 0) && k < 4000) begin
            i_ready = ($urandom_range(0, 3) != 0);
            tick(); k++;
        end
        i_ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok || k >= 4000) begin errors++; $display("FAIL rand_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (n_err != nbad || n_drd != 14) begin errors++; $display("FAIL rand_pulses err=%0d pops=%0d want %0d 14", n_err, n_drd, nbad); end
        checks++;
        if (addr_q.size() != exp_addr.size() || out_q.size() != exp_w.size() || free_q.size() != exp_free.size()) begin
            errors++; $display("FAIL rand_count reads=%0d words=%0d frees=%0d want %0d %0d %0d",
                addr_q.size(), out_q.size(), free_q.size(), exp_addr.size(), exp_w.size(), exp_free.size());
        end
        foreach (exp_addr[i]) if (i < addr_q.size()) begin
            checks++;
            if (int'(addr_q[i]) != exp_addr[i]) begin errors++; $display("FAIL rand_addr%0d got %0d want %0d", i, addr_q[i], exp_addr[i]); end
        end
        foreach (exp_w[i]) if (i < out_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL rand_word%0d got %h want %h", i, out_q[i], exp_w[i]); end
        end
        foreach (exp_free[i]) if (i < free_q.size()) begin
            checks++;
            if (free_q[i] !== exp_free[i]) begin errors++; $display("FAIL rand_free%0d got %b want %b", i, free_q[i], exp_free[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n, k;
        logic [56:0] v;
        clear_q(); i_ready = 1'b1;
        desc_q.push_back(mk(100, 107, 1));
        n = 0; k = 0;
        while (n < 3 && k < 200) begin @(negedge i_clk); if (o_en_read) n++; k++; end
        checks++; if (n < 3) begin errors++; $display("FAIL rst_mid_timeout reads=%0d want 3", n); end
        i_reset = 1'b1;
        #1;
        repeat (3) begin
            v = {o_desc_rd, o_en_read, o_valid, o_sof, o_eof, o_free, o_err, o_busy, o_adr_out, o_data, o_extra_byte};
            checks++;
            if (v !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", v); end
            @(negedge i_clk);
        end
        tick();
        i_reset = 1'b0;
        clear_q();
        tick(6);
        checks++;
        if (out_q.size() != 0 || free_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL rst_mid_residue words=%0d frees=%0d reads=%0d want 0 0 0", out_q.size(), free_q.size(), addr_q.size());
        end
        model_frame(200, 205, 2); desc_q.push_back(mk(200, 205, 2));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout busy=%0b want 0", o_busy); end
        checks++;
        if (out_q.size() != 6 || free_q.size() != 1) begin
            errors++; $display("FAIL rst_next_count words=%0d frees=%0d want 6 1", out_q.size(), free_q.size());
        end
        foreach (exp_w[i]) if (i < out_q.size() && i < addr_q.size()) begin
            checks++;
            if (out_q[i] !== exp_w[i] || int'(addr_q[i]) != exp_addr[i]) begin
                errors++; $display("FAIL rst_next%0d got %0d/%h want %0d/%h", i, addr_q[i], out_q[i], exp_addr[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) sram[i] = $urandom;
        test_reset();
        test_basic();
        test_wrap_single();
        test_bad_desc();
        test_backpressure();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_frame_reader.md
MEM_FRAME_READER -- requirements
Module: mem_frame_reader

Interface
REQ-001 SHALL have parameter pDEPTH_RAM, default 4608, meaning total 32-bit words in the packet SRAM; AW = $clog2(pDEPTH_RAM).
REQ-002 SHALL have parameter pDATA_WIDTH, default 8, meaning byte width; word width = 4*pDATA_WIDTH = 32.
REQ-003 SHALL have parameters pREG1_HI (default 1534), pREG2_LO (default 1535), pREG2_HI (default 3070) and pREG3_LO (default 3071), meaning region bounds; region1 = 0..pREG1_HI, region2 = pREG2_LO..pREG2_HI, region3 = pREG3_LO..pDEPTH_RAM-1.
REQ-004 SHALL have parameter pRD_LAT, default 2, meaning SRAM read latency in cycles from o_en_read to i_data.
REQ-005 SHALL have parameter pOUT_DEPTH, default 4, meaning output buffer entries; pOUT_DEPTH >= pRD_LAT+1.
REQ-006 i_clk  in  1  sole clock; all logic on rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_desc  in  2*AW+2  frame descriptor {extra_byte[1:0], end_addr, start_addr}, show-ahead FIFO head.
REQ-009 i_desc_valid  in  1  descriptor FIFO not empty.
REQ-010 o_desc_rd  out  1  one-cycle pop strobe to the descriptor FIFO.
REQ-011 o_en_read  out  1  SRAM read enable.
REQ-012 o_adr_out  out  AW  SRAM read address.
REQ-013 i_data  in  32  SRAM read data, valid pRD_LAT cycles after o_en_read.
REQ-014 o_data  out  32  frame word.
REQ-015 o_valid  out  1  o_data valid; i_ready  in  1  downstream accepts.
REQ-016 o_sof, o_eof  out  1 each  first/last word of frame, qualified by o_valid.
REQ-017 o_extra_byte  out  2  descriptor extra_byte, valid only on the o_eof word, 0 otherwise.
REQ-018 o_free  out  3  one-hot region release pulse (bit0 = region1).
REQ-019 o_err  out  1  one-cycle pulse on a discarded bad descriptor.
REQ-020 o_busy  out  1  high when not in IDLE, or reads in flight, or output buffer non-empty.

Function
REQ-021 FSM states SHALL be IDLE and READ.
REQ-022 In IDLE with i_desc_valid=1, the block SHALL pulse o_desc_rd and latch i_desc in the same cycle.
REQ-023 After the latch, the FSM SHALL enter READ next cycle, with cur = start_addr, region decoded from start_addr.
REQ-024 Region decode: start <= pREG1_HI -> 1; start <= pREG2_HI -> 2; start <= pDEPTH_RAM-1 -> 3.
REQ-025 A descriptor whose start or end is > pDEPTH_RAM-1, or whose end lies outside the start's region, SHALL be popped and dropped: o_err pulse, no reads issued, FSM stays in IDLE.
REQ-026 In READ, o_en_read=1 with o_adr_out=cur SHALL be issued in each cycle where credit = pOUT_DEPTH - buffer_count - inflight > 0; otherwise o_en_read=0.
REQ-027 After each issue, cur SHALL advance by 1, wrapping from the region HI to the region LO (region1 LO = 0, region3 HI = pDEPTH_RAM-1).
REQ-028 The issue with cur == end_addr SHALL be the last of the frame; the FSM SHALL return to IDLE next cycle (one bubble per frame allowed).
REQ-029 Frame length SHALL be end - start + 1 modulo region size; start == end is a one-word frame with o_sof = o_eof = 1.
REQ-030 sof/eof/extra_byte/region tags SHALL travel through a pRD_LAT-deep pipeline aligned with i_data and be written into the output buffer with the data.
REQ-031 Output buffer SHALL be show-ahead: o_valid = !empty; an entry pops on o_valid & i_ready; order SHALL be preserved.
REQ-032 With i_ready held high, throughput SHALL be one word per cycle within a frame; the buffer SHALL never overflow.
REQ-033 o_free[region] SHALL pulse for one cycle in the cycle after the o_eof word is accepted.
REQ-034 o_valid, o_sof, o_eof and o_data SHALL hold stable while o_valid=1 and i_ready=0.

Reset
REQ-035 On i_reset: FSM->IDLE; cur, latched descriptor, credit pipeline, and output buffer cleared; o_desc_rd, o_en_read, o_valid, o_sof, o_eof, o_free, o_err, o_busy = 0; o_adr_out, o_data, o_extra_byte = 0.
REQ-036 On reset mid-frame, in-flight read data SHALL be discarded and no o_free SHALL be issued for the aborted frame.

Verification
REQ-037 Descriptor {2'd3, end=12, start=10}, i_ready=1 -> reads at 10, 11, 12 on consecutive cycles; 3 words out with sof on word 1, eof and extra_byte=3 on word 3; o_free=3'b001 one cycle later.
REQ-038 Region2 wrap: start=3069, end=1536 -> read addresses 3069, 3070, 1535, 1536; eof on 4th word; o_free=3'b010.
REQ-039 Single word: start=end=3071 -> one read; o_valid word with sof=eof=1; o_free=3'b100.
REQ-040 Backpressure: i_ready=0 for 10 cycles during a 20-word frame -> at most pOUT_DEPTH words buffered; no loss or reorder; o_data stable while stalled.
REQ-041 Bad descriptor with start=10, end=2000 -> o_desc_rd and o_err pulse; no o_en_read; next valid descriptor processed normally.
REQ-042 Assert i_reset during the 3rd read of an 8-word frame -> all outputs 0 within the reset; no o_free; the following descriptor is read from its start cleanly.
